simon_controller: RTL and testbench

SIMON_CONTROLLER -- requirements
Module: simon_controller

---
 rtl/simon_pkg.sv | 33 +++
 rtl/simon_controller.sv | 103 ++++++++++
 tb/tb_simon_controller.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/simon_pkg.sv
// Shared types and output codes for the Simon game controller.
// The state encoding equals the mode_leds code for each state.
package simon_pkg;

    localparam logic [2:0] MODE_INPUT  = 3'b001;
    localparam logic [2:0] MODE_PLAY   = 3'b010;
    localparam logic [2:0] MODE_REPEAT = 3'b100;
    localparam logic [2:0] MODE_DONE   = 3'b111;

    localparam logic [1:0] SEL_INPUT  = 2'b00;
    localparam logic [1:0] SEL_PLAY   = 2'b00;
    localparam logic [1:0] SEL_REPEAT = 2'b01;
    localparam logic [1:0] SEL_DONE   = 2'b10;

    typedef enum logic [2:0] {
        S_INPUT  = MODE_INPUT,
        S_PLAY   = MODE_PLAY,
        S_REPEAT = MODE_REPEAT,
        S_DONE   = MODE_DONE
    } state_e;

    function automatic logic [1:0] sel_of(state_e s);
        logic [1:0] r;
        r = SEL_INPUT;
        case (s)
            S_REPEAT: r = SEL_REPEAT;
            S_DONE:   r = SEL_DONE;
            default:  r = SEL_INPUT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/simon_controller.sv
// Simon game control FSM: INPUT -> PLAYBACK -> REPEAT loop, DONE on error/full.
// Define SIMON_RESTART_EN to let next in DONE start a new game.
module simon_controller
    import simon_pkg::*;
#(
    parameter int MAX_LEN = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       next,
    input  logic       is_legal,
    input  logic       play_gt_count,
    input  logic       repeat_eq_play,
    input  logic       input_eq_pattern,
    output logic [1:0] select,
    output logic [2:0] mode_leds,
    output logic       clrcount,
    output logic       w_en,
    output logic [6:0] entries,
    output logic       win
);

    localparam logic [6:0] LEN = 7'(MAX_LEN);

    state_e     state_q, state_d;
    logic [6:0] entries_q, entries_d;
    logic       win_q, win_d;
    logic       clr_q, clr_d;
    logic       wr_c;
    logic       full;

    assign full = (entries_q >= LEN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_INPUT;
            entries_q <= 7'd0;
            win_q     <= 1'b0;
            clr_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            entries_q <= entries_d;
            win_q     <= win_d;
            clr_q     <= clr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        entries_d = entries_q;
        win_d     = win_q;
        clr_d     = 1'b0;
        wr_c      = 1'b0;
        case (state_q)
            S_INPUT: begin
                // A full memory ends the game even if the pattern is legal.
                if (next) begin
                    if (full) begin
                        state_d = S_DONE;
                        win_d   = 1'b1;
                    end else if (is_legal) begin
                        wr_c      = 1'b1;
                        entries_d = entries_q + 7'd1;
                        state_d   = S_PLAY;
                    end
                end
            end
            S_PLAY: begin
                if (play_gt_count) begin
                    state_d = S_REPEAT;
                end
            end
            S_REPEAT: begin
                if (next) begin
                    if (!input_eq_pattern) begin
                        state_d = S_DONE;
                    end else if (repeat_eq_play) begin
                        state_d = S_INPUT;
                    end
                end
            end
            S_DONE: begin
`ifdef SIMON_RESTART_EN
                if (next) begin
                    state_d   = S_INPUT;
                    entries_d = 7'd0;
                    win_d     = 1'b0;
                    clr_d     = 1'b1;
                end
`endif
            end
            default: state_d = S_INPUT;
        endcase
    end

    assign w_en      = wr_c & rst;
    assign mode_leds = state_q;
    assign select    = sel_of(state_q);
    assign clrcount  = clr_q;
    assign entries   = entries_q;
    assign win       = win_q;

endmodule

// File: tb/tb_simon_controller.sv
// Self-checking bench for simon_controller (MAX_LEN=2), vector table plus scoreboard.
module tb_simon_controller;
    import simon_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       next = 1'b0;
    logic       is_legal = 1'b0;
    logic       play_gt_count = 1'b0;
    logic       repeat_eq_play = 1'b0;
    logic       input_eq_pattern = 1'b0;
    logic [1:0] select;
    logic [2:0] mode_leds;
    logic       clrcount;
    logic       w_en;
    logic [6:0] entries;
    logic       win;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic       nx, lg, pg, re, eq;
        logic       ew;
        logic [2:0] em;
        logic [1:0] es;
        logic [6:0] ee;
        logic       ewin;
        logic       eclr;
    } vec_t;

    vec_t tv_a[$];
    vec_t tv_b[$];
    vec_t exp_q[$];

    simon_controller #(.MAX_LEN(2)) dut (
        .clk(clk),
        .rst(rst),
        .next(next),
        .is_legal(is_legal),
        .play_gt_count(play_gt_count),
        .repeat_eq_play(repeat_eq_play),
        .input_eq_pattern(input_eq_pattern),
        .select(select),
        .mode_leds(mode_leds),
        .clrcount(clrcount),
        .w_en(w_en),
        .entries(entries),
        .win(win)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic nx, lg, pg, re, eq, ew,
        input logic [2:0] em, input logic [1:0] es,
        input int ee, input logic ewin, eclr);
        vec_t v;
        v.nx = nx; v.lg = lg; v.pg = pg; v.re = re; v.eq = eq;
        v.ew = ew; v.em = em; v.es = es; v.ee = 7'(ee);
        v.ewin = ewin; v.eclr = eclr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input vec_t v, input string tag);
        vec_t e;
        next = v.nx; is_legal = v.lg; play_gt_count = v.pg;
        repeat_eq_play = v.re; input_eq_pattern = v.eq;
        #1;
        chk({tag, ".w_en"}, w_en, v.ew);
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, ".mode"}, mode_leds, e.em);
        chk({tag, ".sel"}, select, e.es);
        chk({tag, ".entries"}, entries, e.ee);
        chk({tag, ".win"}, win, e.ewin);
        chk({tag, ".clr"}, clrcount, e.eclr);
        next = 0; is_legal = 0; play_gt_count = 0;
        repeat_eq_play = 0; input_eq_pattern = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        next = 1'b1; is_legal = 1'b1;
        #1;
        chk("rst.mode", mode_leds, MODE_INPUT);
        chk("rst.sel", select, SEL_INPUT);
        chk("rst.entries", entries, 0);
        chk("rst.win", win, 0);
        chk("rst.w_en", w_en, 0);
        chk("rst.clr", clrcount, 1);
        next = 1'b0; is_legal = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rel.clr", clrcount, 1);
        chk("rel.mode", mode_leds, MODE_INPUT);
    endtask

    initial begin
        // Full game with MAX_LEN=2: two correct rounds, then memory full.
        tv_a.push_back(mk(0,0,0,0,0, 0, MODE_INPUT, SEL_INPUT, 0, 0, 0));
        tv_a.push_back(mk(1,0,0,0,0, 0, MODE_INPUT, SEL_INPUT, 0, 0, 0));
        tv_a.push_back(mk(1,1,0,0,0, 1, MODE_PLAY, SEL_PLAY, 1, 0, 0));
        tv_a.push_back(mk(1,1,0,0,0, 0, MODE_PLAY, SEL_PLAY, 1, 0, 0));
        tv_a.push_back(mk(0,0,1,0,0, 0, MODE_REPEAT, SEL_REPEAT, 1, 0, 0));
        tv_a.push_back(mk(0,0,0,1,1, 0, MODE_REPEAT, SEL_REPEAT, 1, 0, 0));
        tv_a.push_back(mk(1,0,0,0,1, 0, MODE_REPEAT, SEL_REPEAT, 1, 0, 0));
        tv_a.push_back(mk(1,0,0,1,1, 0, MODE_INPUT, SEL_INPUT, 1, 0, 0));
        tv_a.push_back(mk(1,1,0,0,0, 1, MODE_PLAY, SEL_PLAY, 2, 0, 0));
        tv_a.push_back(mk(0,0,1,0,0, 0, MODE_REPEAT, SEL_REPEAT, 2, 0, 0));
        tv_a.push_back(mk(1,0,0,1,1, 0, MODE_INPUT, SEL_INPUT, 2, 0, 0));
        tv_a.push_back(mk(1,1,0,0,0, 0, MODE_DONE, SEL_DONE, 2, 1, 0));
`ifdef SIMON_RESTART_EN
        tv_a.push_back(mk(1,0,0,0,0, 0, MODE_INPUT, SEL_INPUT, 0, 0, 1));
        tv_a.push_back(mk(0,0,0,0,0, 0, MODE_INPUT, SEL_INPUT, 0, 0, 0));
`else
        tv_a.push_back(mk(1,1,0,0,0, 0, MODE_DONE, SEL_DONE, 2, 1, 0));
        tv_a.push_back(mk(0,0,0,0,0, 0, MODE_DONE, SEL_DONE, 2, 1, 0));
`endif
        // Lost game: wrong repeat input.
        tv_b.push_back(mk(0,0,0,0,0, 0, MODE_INPUT, SEL_INPUT, 0, 0, 0));
        tv_b.push_back(mk(1,1,0,0,0, 1, MODE_PLAY, SEL_PLAY, 1, 0, 0));
        tv_b.push_back(mk(0,0,1,0,0, 0, MODE_REPEAT, SEL_REPEAT, 1, 0, 0));
        tv_b.push_back(mk(1,0,0,1,0, 0, MODE_DONE, SEL_DONE, 1, 0, 0));
`ifdef SIMON_RESTART_EN
        tv_b.push_back(mk(1,0,0,0,0, 0, MODE_INPUT, SEL_INPUT, 0, 0, 1));
        tv_b.push_back(mk(1,0,0,0,0, 0, MODE_INPUT, SEL_INPUT, 0, 0, 0));
`else
        tv_b.push_back(mk(1,0,0,0,0, 0, MODE_DONE, SEL_DONE, 1, 0, 0));
        tv_b.push_back(mk(1,1,0,0,0, 0, MODE_DONE, SEL_DONE, 1, 0, 0));
`endif

        do_reset();
        foreach (tv_a[i]) step(tv_a[i], $sformatf("a%0d", i));

        do_reset();
        foreach (tv_b[i]) step(tv_b[i], $sformatf("b%0d", i));

        // Asynchronous reset in the middle of REPEAT.
        do_reset();
        step(mk(1,1,0,0,0, 1, MODE_PLAY, SEL_PLAY, 1, 0, 0), "c0");
        step(mk(0,0,1,0,0, 0, MODE_REPEAT, SEL_REPEAT, 1, 0, 0), "c1");
        #2;
        rst = 1'b0;
        #1;
        chk("midrst.mode", mode_leds, MODE_INPUT);
        chk("midrst.sel", select, SEL_INPUT);
        chk("midrst.entries", entries, 0);
        chk("midrst.clr", clrcount, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        step(mk(0,0,0,0,0, 0, MODE_INPUT, SEL_INPUT, 0, 0, 0), "c2");

        chk("sb.empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
